digit_serial_adder: RTL and testbench
=====================================

// Module: digit_serial_adder
// PURPOSE
//  Parametrised multi-cycle unsigned adder; successor to the fixed 5+6-bit ripple adder.
//  Adds operand A (WA bits) and B (WB bits) DW bits per clock, carry held in a register.
//  Valid/ready handshake on both sides. Used in the ALU datapath where area matters more
//  than latency. Result width is max(WA,WB)+1.
// PARAMETERS
//  WA  5  width of operand A (>=1)
//  WB  6  width of operand B (>=1)
//  DW  2  digit width added per cycle (1..W)
//  Derived: W = max(WA,WB); NDIG = ceil(W/DW); P = NDIG*DW (internal padded width)
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operands presented
//  in_ready   out  1    block accepts operands this cycle
//  a          in   WA   operand A, unsigned
//  b          in   WB   operand B, unsigned
//  sub        in   1    1 = A-B (only with DSA_SUB_EN; else ignored)
//  out_valid  out  1    sum is valid
//  out_ready  in   1    consumer takes sum
//  sum        out  W+1  result; sum[W] = carry-out (borrow flag in sub mode)
//  busy       out  1    1 while in RUN
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, in_ready=0 during reset then 1, out_valid=0,
//    sum=0, busy=0, digit counter=0, carry=0. Reset mid-RUN/DONE abandons the op, no output.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&in_ready: latch a,b zero-extended to P bits, cnt=0,
//          carry=0 -> RUN.
//    RUN:  per cycle add digit cnt of A and B plus carry; write DW sum bits into result
//          reg at digit position cnt; carry <= digit carry-out; cnt++. After digit NDIG-1
//          -> DONE. in_ready=0, busy=1.
//    DONE: out_valid=1; sum held stable until out_ready=1. On out_ready -> IDLE, or
//          directly RUN if in_valid=1 in same cycle (in_ready = IDLE | (DONE & out_ready)).
//  - Latency: out_valid rises NDIG clock edges after the accepting edge.
//    Back-to-back throughput: one op per NDIG+1 cycles.
//  - sum[W-1:0] = (A+B) mod 2^W; sum[W] = bit W of the padded P-bit sum (= true carry
//    out of W bits; padding bits of both operands are 0). When P>W, bits above W are
//    discarded.
//  - out_valid and sum only change on DONE entry/exit; sum keeps last value in IDLE/RUN.
//  - in_valid while not in_ready is ignored (no capture); a/b may change freely during RUN.
//  - out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  DSA_SUB_EN defined: sub latched with operands; when 1, B's low W bits are inverted
//    (padding stays 0) and initial carry=1; sum[W-1:0] = (A-B) mod 2^W,
//    sum[W] = ~carry-out = 1 iff A<B (borrow).
//  DSA_SUB_EN undefined: sub port present but unused; add only.
// TESTING (WA=5, WB=6, DW=2 -> W=6, NDIG=3 unless stated)
//  1 a=31,b=63 accepted -> out_valid 3 edges later, sum=94 (7'b1011110), busy=1 for 3 cycles.
//  2 a=0,b=0 then out_ready held low 5 cycles -> sum=0, out_valid stays 1, in_ready=0,
//    sum stable throughout.
//  3 Back-to-back: 1+1 and 20+40 with in_valid/out_ready high -> sums 2 then 60, second
//    accepted same cycle first is consumed.
//  4 rst_n low during 2nd RUN cycle of 31+63 -> out_valid=0, sum=0 immediately; after
//    release, new op 5+6 -> sum=11.
//  5 DW=4 (P=8>W): a=31,b=33 -> sum=64 (carry into bit 6 correct, padding ignored).
//  6 DSA_SUB_EN: a=5,b=9,sub=1 -> sum[5:0]=60, sum[6]=1; a=9,b=5 -> sum=4, sum[6]=0.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial unsigned adder: adds DW bits of A and B per clock with a carry register.
// Optional subtract mode (A-B, borrow in sum[W]) enabled by defining DSA_SUB_EN.
module digit_serial_adder #(
    parameter int unsigned WA = 5,
    parameter int unsigned WB = 6,
    parameter int unsigned DW = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WA-1:0]                       a,
    input  logic [WB-1:0]                       b,
    input  logic                                sub,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [((WA > WB) ? WA : WB):0]      sum,
    output logic                                busy
);

    localparam int unsigned W    = (WA > WB) ? WA : WB;
    localparam int unsigned NDIG = (W + DW - 1) / DW;
    localparam int unsigned P    = NDIG * DW;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [P-1:0] B_MASK = P'({W{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [P-1:0]    op_a_q, op_a_d;
    logic [P-1:0]    op_b_q, op_b_d;
    logic [P-1:0]    res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W:0]      sum_q, sum_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [DW:0]     digit_sum;
    logic            in_ready_c;
    logic            accept;
    logic            sub_sel;

`ifdef DSA_SUB_EN
    assign sub_sel = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_sel    = 1'b0;
`endif

    // A finishing op can hand over to a new one in the same cycle it is consumed.
    assign in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign in_ready   = rst_n && in_ready_c;
    assign accept     = in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        digit_sum   = (DW+1)'(op_a_q[DW-1:0]) + (DW+1)'(op_b_q[DW-1:0]) + (DW+1)'(carry_q);

        case (state_q)
            S_RUN: begin
                // Operands shift down one digit per cycle; result digits shift in from the top.
                op_a_d  = op_a_q >> DW;
                op_b_d  = op_b_q >> DW;
                res_d   = P'({digit_sum[DW-1:0], res_q} >> DW);
                carry_d = digit_sum[DW];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    sum_d       = (W+1)'({digit_sum[DW], res_d});
                    sum_d[W]    = sum_d[W] ^ sub_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            S_IDLE: ;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_RUN;
            op_a_d  = P'(a);
            op_b_d  = P'(b) ^ (sub_sel ? B_MASK : '0);
            carry_d = sub_sel;
            sub_d   = sub_sel;
            cnt_d   = '0;
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: DW=2 instance (NDIG=3) and DW=4 instance (P>W).
module tb_digit_serial_adder;

`ifdef DSA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid0 = 1'b0, in_ready0, sub0 = 1'b0, out_valid0, out_ready0 = 1'b0, busy0;
    logic [4:0] a0 = '0;
    logic [5:0] b0 = '0;
    logic [6:0] sum0;

    logic       in_valid1 = 1'b0, in_ready1, sub1 = 1'b0, out_valid1, out_ready1 = 1'b1, busy1;
    logic [4:0] a1 = '0;
    logic [5:0] b1 = '0;
    logic [6:0] sum1;

    digit_serial_adder #(.WA(5), .WB(6), .DW(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .busy(busy0)
    );

    digit_serial_adder #(.WA(5), .WB(6), .DW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;
    logic [6:0] exp0[$];
    logic [6:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitors: compare each consumed result against the oldest expected value.
    always begin : mon0
        logic [6:0] e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid0 && out_ready0) begin
            if (exp0.size() == 0) check("sum0_unexpected_output", 32'(out_valid0), 32'(0));
            else begin
                e = exp0.pop_front();
                check("sum0", 32'(sum0), 32'(e));
            end
        end
    end

    always begin : mon1
        logic [6:0] e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid1 && out_ready1) begin
            if (exp1.size() == 0) check("sum1_unexpected_output", 32'(out_valid1), 32'(0));
            else begin
                e = exp1.pop_front();
                check("sum1", 32'(sum1), 32'(e));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send0(input logic [4:0] ta, input logic [5:0] tb, input logic ts,
                         input logic [6:0] e, output logic ov_at_acc);
        int k = 0;
        #1;
        a0 = ta; b0 = tb; sub0 = ts; in_valid0 = 1'b1;
        while (!in_ready0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        ov_at_acc = out_valid0;
        if (k >= 40) check("send0_accept_timeout", 32'(in_ready0), 32'(1));
        else exp0.push_back(e);
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [4:0] ta, input logic [5:0] tb, input logic ts,
                         input logic [6:0] e);
        int k = 0;
        #1;
        a1 = ta; b1 = tb; sub1 = ts; in_valid1 = 1'b1;
        while (!in_ready1 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 40) check("send1_accept_timeout", 32'(in_ready1), 32'(1));
        else exp1.push_back(e);
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic drain(input int which);
        int k = 0;
        while (((which == 0) ? exp0.size() : exp1.size()) != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #2;
        if (which == 0) check("drain0_queue_empty", 32'(exp0.size()), 32'(0));
        else            check("drain1_queue_empty", 32'(exp1.size()), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic ov;
        int   k;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready0), 32'(0));
        check("rst_out_valid", 32'(out_valid0), 32'(0));
        check("rst_sum", 32'(sum0), 32'(0));
        check("rst_busy", 32'(busy0), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready0), 32'(1));

        // 31+63: latency of 3 edges, busy for 3 cycles
        out_ready0 = 1'b1;
        send0(5'd31, 6'd63, 1'b0, 7'd94, ov);
        check("t1_busy_c0", 32'(busy0), 32'(1));
        check("t1_in_ready_run", 32'(in_ready0), 32'(0));
        @(negedge clk);
        check("t1_busy_c1", 32'(busy0), 32'(1));
        check("t1_ov_c1", 32'(out_valid0), 32'(0));
        @(negedge clk);
        check("t1_busy_c2", 32'(busy0), 32'(1));
        check("t1_ov_c2", 32'(out_valid0), 32'(0));
        @(negedge clk);
        check("t1_ov_c3", 32'(out_valid0), 32'(1));
        check("t1_busy_c3", 32'(busy0), 32'(0));
        check("t1_sum", 32'(sum0), 32'(94));
        drain(0);

        // 0+0 with consumer stalled for 5 cycles; stray in_valid must be ignored
        out_ready0 = 1'b0;
        send0(5'd0, 6'd0, 1'b0, 7'd0, ov);
        k = 0;
        while (!out_valid0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t2_reached_done", 32'(out_valid0), 32'(1));
        a0 = 5'd7; b0 = 6'd7; in_valid0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stall_ov", 32'(out_valid0), 32'(1));
            check("t2_stall_in_ready", 32'(in_ready0), 32'(0));
            check("t2_stall_sum", 32'(sum0), 32'(0));
        end
        in_valid0 = 1'b0;
        @(negedge clk);
        out_ready0 = 1'b1;
        drain(0);

        // Back-to-back: second op accepted in the cycle the first is consumed
        send0(5'd1, 6'd1, 1'b0, 7'd2, ov);
        send0(5'd20, 6'd40, 1'b0, 7'd60, ov);
        check("t3_accept_on_consume", 32'(ov), 32'(1));
        drain(0);
        @(negedge clk);
        check("t3_idle_ov", 32'(out_valid0), 32'(0));
        check("t3_sum_held", 32'(sum0), 32'(60));

        // Carry boundaries
        send0(5'd31, 6'd32, 1'b0, 7'd63, ov);
        send0(5'd0, 6'd63, 1'b0, 7'd63, ov);
        send0(5'd1, 6'd63, 1'b0, 7'd64, ov);
        drain(0);

        // Reset during the second RUN cycle abandons the op
        send0(5'd31, 6'd63, 1'b0, 7'd94, ov);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_ov", 32'(out_valid0), 32'(0));
        check("t4_rst_sum", 32'(sum0), 32'(0));
        check("t4_rst_busy", 32'(busy0), 32'(0));
        check("t4_rst_in_ready", 32'(in_ready0), 32'(0));
        exp0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_no_output", 32'(out_valid0), 32'(0));
        check("t4_in_ready", 32'(in_ready0), 32'(1));
        send0(5'd5, 6'd6, 1'b0, 7'd11, ov);
        drain(0);

        // Subtract mode (ignored unless enabled)
        send0(5'd5, 6'd9, 1'b1, SUB_EN ? 7'd124 : 7'd14, ov);
        send0(5'd9, 6'd5, 1'b1, SUB_EN ? 7'd4 : 7'd14, ov);
        send0(5'd0, 6'd0, 1'b1, SUB_EN ? 7'd0 : 7'd0, ov);
        send0(5'd31, 6'd63, 1'b0, 7'd94, ov);
        drain(0);

        // DW=4 instance: P=8 > W=6, NDIG=2
        send1(5'd31, 6'd33, 1'b0, 7'd64);
        @(negedge clk);
        check("t5_ov_c1", 32'(out_valid1), 32'(0));
        @(negedge clk);
        check("t5_ov_c2", 32'(out_valid1), 32'(1));
        check("t5_sum", 32'(sum1), 32'(64));
        drain(1);
        send1(5'd31, 6'd63, 1'b0, 7'd94);
        send1(5'd17, 6'd14, 1'b0, 7'd31);
        send1(5'd5, 6'd9, 1'b1, SUB_EN ? 7'd124 : 7'd14);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
